pic_fetch_pc_unit: RTL and testbench
====================================

Name: pic_fetch_pc_unit

Overview:
- Program-counter, fetch and return-stack stage of the 14-bit-instruction core.
- Drives the 13-bit program address to program memory and captures the returned 14-bit word into the instruction register.
- Resolves GOTO/CALL/RETURN/RETLW/RETFIE, ALU-signalled skips and computed PCL writes, flushing the one wrong-path word each time, which gives the 2-cycle branch cost.
- Owns the 8-level hardware return stack.

Parameters:
- STACK_DEPTH, 8, return-stack entries; power of two, 2..16.
- RESET_VECTOR, 13'h0000, PC value loaded on reset.

Ports:
- clk_i  in  1  core clock, rising edge.
- pon_rst_n_i  in  1  asynchronous active-low power-on reset.
- stall_i  in  1  holds every register when 1.
- prog_adr_o  out  13  program-memory address; combinational copy of pc register.
- prog_dat_i  in  14  program word for prog_adr_o, valid in the same cycle (combinational ROM).
- ir_o  out  14  instruction register to execute stage.
- ir_valid_o  out  1  ir_o holds a real instruction (0 = flushed bubble).
- ir_pc_o  out  13  address of the instruction in ir_o.
- skip_i  in  1  execute stage: current ir instruction is a skip whose condition is true.
- pcl_wr_i  in  1  execute stage writes PCL this cycle.
- pcl_dat_i  in  8  new PCL value.
- pclath_i  in  5  current PCLATH register.
- stk_ovf_o  out  1  sticky: push while stack full.
- stk_unf_o  out  1  sticky: pop while stack empty.

Behaviour:
- Reset (async assert, sync-safe release):
  - pc = RESET_VECTOR; prog_adr_o therefore equals RESET_VECTOR during reset.
  - ir_o = 14'h0000, ir_valid_o = 0, ir_pc_o = 0.
  - Stack pointer = 0, depth count = 0, all stack entries = 0; stk_ovf_o = stk_unf_o = 0.
- Stall: stall_i = 1 freezes all state including the flags; stall has priority over every event below.
- Normal cycle (no event): ir_o <= prog_dat_i, ir_pc_o <= pc, ir_valid_o <= 1, pc <= pc+1.
  - 13-bit wrap: 0x1FFF -> 0x0000.
- Events are evaluated on ir_o only when ir_valid_o = 1. Every event flushes: ir_o <= 14'h0000, ir_valid_o <= 0, ir_pc_o <= pc.
  - GOTO (ir[13:11] = 101): pc <= {pclath_i[4:3], ir[10:0]}.
  - CALL (ir[13:11] = 100): push pc (= ir_pc_o+1, the return address); pc <= {pclath_i[4:3], ir[10:0]}.
  - RETURN (14'h0008), RETFIE (14'h0009), RETLW (ir[13:10] = 1101): pc <= top of stack; pop.
  - skip_i = 1 (not a control opcode): pc <= pc+1. The word fetched this cycle is discarded.
  - pcl_wr_i = 1 (not a control opcode): pc <= {pclath_i, pcl_dat_i}.
  - Priority when several are active: control opcode > pcl_wr_i > skip_i.
  - skip_i and pcl_wr_i are ignored when ir_valid_o = 0.
- Stack: circular, pointer log2(STACK_DEPTH) bits, depth counter 0..STACK_DEPTH.
  - Push: write entry[ptr], ptr+1, depth+1 saturating at STACK_DEPTH.
  - Push at depth = STACK_DEPTH: overwrite the oldest entry (wrap), set stk_ovf_o.
  - Pop: ptr-1, read entry[ptr-1], depth-1.
  - Pop at depth 0: ptr still wraps, returns whatever entry is addressed, set stk_unf_o, depth stays 0.
  - Flags clear only on reset.
- Latency:
  - Control transfer or skip: one bubble cycle. The target word is in ir_o 2 cycles after the branch entered ir_o.
  - Back-to-back branches are impossible, because a bubble always follows a branch.
- Reset mid-branch: all pending state is discarded; fetch restarts at RESET_VECTOR.

Test Plan:
- Reset, ROM holds sequential NOPs -> prog_adr_o 0,1,2,3 on consecutive cycles; ir_valid_o goes 0 then 1; ir_pc_o trails prog_adr_o by one.
- GOTO 0x123 at address 5, pclath_i = 5'b11000 -> one bubble (ir_valid_o = 0), then prog_adr_o = 0x1923.
- CALL 0x050 at 0x010, then RETURN at 0x050 -> stack receives 0x011; after RETURN, prog_adr_o = 0x011; two bubbles total.
- Nine nested CALLs, then nine RETURNs -> stk_ovf_o = 1 after the 9th CALL; first return goes to the 9th return address; stk_unf_o = 1 on the 9th RETURN.
- skip_i = 1 on the instruction at 0x020 -> the word at 0x021 is squashed; next valid ir_pc_o = 0x022.
- pcl_wr_i = 1, pcl_dat_i = 0x80, pclath_i = 0x03 -> bubble, then prog_adr_o = 0x0380.
- stall_i held for 3 cycles mid-CALL -> all outputs frozen; the sequence resumes identically after release.

Source files
------------

// File: rtl/pic_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pic_fetch_pc_unit
// Description : Program counter, instruction fetch and hardware return stack
//               for a 14-bit-instruction core. Resolves GOTO/CALL/RETURN/
//               RETLW/RETFIE, execute-stage skips and computed PCL writes by
//               flushing the single wrong-path word that was fetched.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_fetch_pc_unit #(
    parameter int          STACK_DEPTH  = 8,
    parameter logic [12:0] RESET_VECTOR = 13'h0000
) (
    input  logic        clk_i,
    input  logic        pon_rst_n_i,
    input  logic        stall_i,
    output logic [12:0] prog_adr_o,
    input  logic [13:0] prog_dat_i,
    output logic [13:0] ir_o,
    output logic        ir_valid_o,
    output logic [12:0] ir_pc_o,
    input  logic        skip_i,
    input  logic        pcl_wr_i,
    input  logic [7:0]  pcl_dat_i,
    input  logic [4:0]  pclath_i,
    output logic        stk_ovf_o,
    output logic        stk_unf_o
);

    localparam int                   c_ptr_w      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int                   c_depth_w    = $clog2(STACK_DEPTH + 1);
    localparam logic [c_ptr_w-1:0]   c_ptr_one    = 1;
    localparam logic [c_depth_w-1:0] c_depth_one  = 1;
    localparam logic [c_depth_w-1:0] c_depth_full = c_depth_w'(STACK_DEPTH);

    // Architectural state
    logic [12:0]          r_pc;
    logic [13:0]          r_ir;
    logic                 r_ir_valid;
    logic [12:0]          r_ir_pc;
    logic [12:0]          r_stack [STACK_DEPTH];
    logic [c_ptr_w-1:0]   r_ptr;
    logic [c_depth_w-1:0] r_depth;
    logic                 r_ovf;
    logic                 r_unf;

    // Decode and next-PC selection
    logic                 w_is_goto;
    logic                 w_is_call;
    logic                 w_is_ret;
    logic                 w_ctrl;
    logic                 w_pcl;
    logic                 w_skip;
    logic                 w_flush;
    logic [12:0]          w_pc_inc;
    logic [12:0]          w_pc_next;
    logic [c_ptr_w-1:0]   w_ptr_inc;
    logic [c_ptr_w-1:0]   w_ptr_dec;

    assign prog_adr_o = r_pc;
    assign ir_o       = r_ir;
    assign ir_valid_o = r_ir_valid;
    assign ir_pc_o    = r_ir_pc;
    assign stk_ovf_o  = r_ovf;
    assign stk_unf_o  = r_unf;

    // Decode the instruction register and pick the next PC; a bubble in IR
    // never triggers any event, so execute-stage strobes are gated by valid.
    always_comb begin
        w_is_goto = r_ir_valid && (r_ir[13:11] == 3'b101);
        w_is_call = r_ir_valid && (r_ir[13:11] == 3'b100);
        w_is_ret  = r_ir_valid && ((r_ir == 14'h0008) || (r_ir == 14'h0009) ||
                                   (r_ir[13:10] == 4'b1101));
        w_ctrl    = w_is_goto || w_is_call || w_is_ret;
        w_pcl     = r_ir_valid && pcl_wr_i && !w_ctrl;
        w_skip    = r_ir_valid && skip_i && !w_ctrl && !w_pcl;
        w_flush   = w_ctrl || w_pcl || w_skip;
        w_pc_inc  = r_pc + 13'd1;
        w_ptr_inc = r_ptr + c_ptr_one;
        w_ptr_dec = r_ptr - c_ptr_one;
        w_pc_next = w_pc_inc;
        if (w_is_ret) begin
            w_pc_next = r_stack[w_ptr_dec];
        end else if (w_is_goto || w_is_call) begin
            w_pc_next = {pclath_i[4:3], r_ir[10:0]};
        end else if (w_pcl) begin
            w_pc_next = {pclath_i, pcl_dat_i};
        end
    end

    // PC and instruction register: fetch every cycle, squash the fetched word
    // whenever the current instruction redirects the flow.
    always_ff @(posedge clk_i or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            r_pc       <= RESET_VECTOR;
            r_ir       <= 14'h0000;
            r_ir_valid <= 1'b0;
            r_ir_pc    <= 13'h0000;
        end else if (!stall_i) begin
            r_pc    <= w_pc_next;
            r_ir_pc <= r_pc;
            if (w_flush) begin
                r_ir       <= 14'h0000;
                r_ir_valid <= 1'b0;
            end else begin
                r_ir       <= prog_dat_i;
                r_ir_valid <= 1'b1;
            end
        end
    end

    // Circular return stack: a push when full overwrites the oldest entry,
    // a pop when empty still moves the pointer; both raise sticky flags.
    always_ff @(posedge clk_i or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= 13'h0000;
            end
            r_ptr   <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (!stall_i) begin
            if (w_is_call) begin
                r_stack[r_ptr] <= r_pc;
                r_ptr          <= w_ptr_inc;
                if (r_depth == c_depth_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_depth <= r_depth + c_depth_one;
                end
            end else if (w_is_ret) begin
                r_ptr <= w_ptr_dec;
                if (r_depth == '0) begin
                    r_unf <= 1'b1;
                end else begin
                    r_depth <= r_depth - c_depth_one;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pic_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_fetch_pc_unit
// Description : Self-checking bench for pic_fetch_pc_unit. Per-cycle vectors
//               are built into a table, expected state is queued as each row
//               is driven and popped when the clock edge has produced output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [12:0] prog_adr;
    logic [13:0] prog_dat;
    logic [13:0] ir;
    logic        ir_valid;
    logic [12:0] ir_pc;
    logic        skip;
    logic        pcl_wr;
    logic [7:0]  pcl_dat;
    logic [4:0]  pclath;
    logic        stk_ovf;
    logic        stk_unf;

    always #5 clk = ~clk;

    pic_fetch_pc_unit #(
        .STACK_DEPTH (8),
        .RESET_VECTOR(13'h0000)
    ) dut (
        .clk_i      (clk),
        .pon_rst_n_i(rst_n),
        .stall_i    (stall),
        .prog_adr_o (prog_adr),
        .prog_dat_i (prog_dat),
        .ir_o       (ir),
        .ir_valid_o (ir_valid),
        .ir_pc_o    (ir_pc),
        .skip_i     (skip),
        .pcl_wr_i   (pcl_wr),
        .pcl_dat_i  (pcl_dat),
        .pclath_i   (pclath),
        .stk_ovf_o  (stk_ovf),
        .stk_unf_o  (stk_unf)
    );

    // Combinational program ROM
    logic [13:0] rom [0:8191];
    assign prog_dat = rom[prog_adr];

    typedef struct {
        logic        skip;
        logic        pcl_wr;
        logic [7:0]  pcl_dat;
        logic [4:0]  pclath;
        logic        stall;
        logic [12:0] adr;
        logic        valid;
        logic [12:0] irpc;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   row_id = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (row %0d): got %0h, want %0h", name, row_id, act, exp);
        end
    endtask

    // Compare every output against an expected record; IR content follows
    // from the ROM image at the expected instruction address.
    task automatic check(input vec_t e);
        logic [13:0] exp_ir;
        exp_ir = e.valid ? rom[e.irpc] : 14'h0000;
        cmp("prog_adr", 32'(prog_adr), 32'(e.adr));
        cmp("ir_valid", 32'(ir_valid), 32'(e.valid));
        cmp("ir_pc",    32'(ir_pc),    32'(e.irpc));
        cmp("ir",       32'(ir),       32'(exp_ir));
        cmp("stk_ovf",  32'(stk_ovf),  32'(e.ovf));
        cmp("stk_unf",  32'(stk_unf),  32'(e.unf));
    endtask

    task automatic add(input logic s, input logic pw, input logic [7:0] pd, input logic [4:0] pl,
                       input logic st, input logic [12:0] adr, input logic v,
                       input logic [12:0] irpc, input logic ovf, input logic unf);
        vec_t r;
        r.skip = s; r.pcl_wr = pw; r.pcl_dat = pd; r.pclath = pl; r.stall = st;
        r.adr = adr; r.valid = v; r.irpc = irpc; r.ovf = ovf; r.unf = unf;
        tbl.push_back(r);
    endtask

    // n plain sequential fetches starting from PC = start
    task automatic ramp(input logic [12:0] start, input int n, input logic [4:0] pl);
        for (int i = 0; i < n; i++) begin
            add(1'b0, 1'b0, 8'h00, pl, 1'b0, 13'(start + 13'(i) + 13'd1), 1'b1,
                13'(start + 13'(i)), 1'b0, 1'b0);
        end
    endtask

    // Apply every row from a negedge; result is checked 1 ns after the posedge.
    task automatic run_table();
        vec_t e;
        foreach (tbl[i]) begin
            skip    = tbl[i].skip;
            pcl_wr  = tbl[i].pcl_wr;
            pcl_dat = tbl[i].pcl_dat;
            pclath  = tbl[i].pclath;
            stall   = tbl[i].stall;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check(e);
            row_id++;
            @(negedge clk);
        end
        tbl.delete();
        skip = 1'b0; pcl_wr = 1'b0; stall = 1'b0;
    endtask

    // Asynchronous reset assertion (checked before any clock edge), held one
    // edge, released on a negedge.
    task automatic restart();
        vec_t r;
        r.skip = 0; r.pcl_wr = 0; r.pcl_dat = 0; r.pclath = 0; r.stall = 0;
        r.adr = 13'h0000; r.valid = 1'b0; r.irpc = 13'h0000; r.ovf = 1'b0; r.unf = 1'b0;
        skip = 1'b0; pcl_wr = 1'b0; pcl_dat = 8'h00; pclath = 5'h00; stall = 1'b0;
        #1 rst_n = 1'b0;
        #1 check(r);
        @(posedge clk);
        #1 check(r);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 8192; a++) rom[a] = 14'h0000;
    endtask

    logic [12:0] ret_tgt [9];
    logic [12:0] site;

    initial begin
        rst_n = 1'b0; stall = 1'b0; skip = 1'b0; pcl_wr = 1'b0;
        pcl_dat = 8'h00; pclath = 5'h00;
        clear_rom();
        @(negedge clk);

        // Sequential NOPs from the reset vector
        restart();
        ramp(13'h0000, 3, 5'h00);
        run_table();

        // GOTO 0x123 at 0x005 with PCLATH[4:3] = 11, reset during the bubble
        rom[5] = 14'h2923;
        restart();
        ramp(13'h0000, 6, 5'h18);
        add(0, 0, 8'h00, 5'h18, 0, 13'h1923, 0, 13'h0006, 0, 0);
        run_table();
        restart();
        ramp(13'h0000, 2, 5'h00);
        run_table();

        // Same GOTO allowed to complete
        restart();
        ramp(13'h0000, 6, 5'h18);
        add(0, 0, 8'h00, 5'h18, 0, 13'h1923, 0, 13'h0006, 0, 0);
        ramp(13'h1923, 2, 5'h18);
        run_table();

        // CALL 0x050 at 0x010, RETURN at 0x050
        clear_rom();
        rom[13'h010] = 14'h2050;
        rom[13'h050] = 14'h0008;
        restart();
        ramp(13'h0000, 17, 5'h00);
        add(0, 0, 8'h00, 5'h00, 0, 13'h0050, 0, 13'h0011, 0, 0);
        ramp(13'h0050, 1, 5'h00);
        add(0, 0, 8'h00, 5'h00, 0, 13'h0011, 0, 13'h0051, 0, 0);
        ramp(13'h0011, 2, 5'h00);
        run_table();

        // Same program with a 3-cycle stall while the CALL sits in IR
        // (strobes asserted during the stall must be ignored) and one more in the bubble
        restart();
        ramp(13'h0000, 17, 5'h00);
        for (int i = 0; i < 3; i++) add(1, 1, 8'hAA, 5'h1F, 1, 13'h0011, 1, 13'h0010, 0, 0);
        add(0, 0, 8'h00, 5'h00, 0, 13'h0050, 0, 13'h0011, 0, 0);
        add(0, 0, 8'h00, 5'h00, 1, 13'h0050, 0, 13'h0011, 0, 0);
        ramp(13'h0050, 1, 5'h00);
        add(0, 0, 8'h00, 5'h00, 0, 13'h0011, 0, 13'h0051, 0, 0);
        ramp(13'h0011, 1, 5'h00);
        run_table();

        // Skip on the instruction at 0x020 squashes 0x021
        clear_rom();
        restart();
        ramp(13'h0000, 33, 5'h00);
        add(1, 0, 8'h00, 5'h00, 0, 13'h0022, 0, 13'h0021, 0, 0);
        ramp(13'h0022, 2, 5'h00);
        run_table();

        // Computed PCL write: {PCLATH=0x03, PCL=0x80}
        restart();
        ramp(13'h0000, 3, 5'h03);
        add(0, 1, 8'h80, 5'h03, 0, 13'h0380, 0, 13'h0003, 0, 0);
        ramp(13'h0380, 2, 5'h03);
        run_table();

        // Priority: opcode over pcl_wr over skip; strobes ignored on a bubble
        rom[2] = 14'h2900;
        restart();
        ramp(13'h0000, 3, 5'h00);
        add(1, 1, 8'h44, 5'h00, 0, 13'h0100, 0, 13'h0003, 0, 0);
        add(1, 1, 8'h44, 5'h00, 0, 13'h0101, 1, 13'h0100, 0, 0);
        add(1, 1, 8'h10, 5'h01, 0, 13'h0110, 0, 13'h0101, 0, 0);
        ramp(13'h0110, 1, 5'h00);
        run_table();

        // 13-bit wrap: GOTO to 0x1FFF, then sequential fetch wraps to 0x0000
        clear_rom();
        rom[0] = 14'h2FFF;
        restart();
        ramp(13'h0000, 1, 5'h18);
        add(0, 0, 8'h00, 5'h18, 0, 13'h1FFF, 0, 13'h0001, 0, 0);
        ramp(13'h1FFF, 2, 5'h18);
        run_table();

        // Nine nested CALLs (site k*0x40 calls (k+1)*0x40), then nine returns
        // using RETURN/RETFIE/RETLW. Returns go to 0x201,0x1C1..0x041; the
        // ninth pops an empty stack and lands on the wrapped entry 0x201.
        clear_rom();
        for (int k = 0; k < 9; k++) rom[k * 64] = 14'h2000 | 14'((k + 1) * 64);
        for (int j = 0; j < 8; j++) ret_tgt[j] = 13'((8 - j) * 64 + 1);
        ret_tgt[8] = 13'h0201;
        site = 13'h0240;
        for (int j = 0; j < 9; j++) begin
            rom[site] = (j % 3 == 0) ? 14'h0008 : (j % 3 == 1) ? 14'h0009 : 14'h3455;
            site = ret_tgt[j];
        end
        restart();
        for (int k = 0; k < 9; k++) begin
            add(0, 0, 8'h00, 5'h00, 0, 13'(k * 64 + 1), 1, 13'(k * 64), 0, 0);
            add(0, 0, 8'h00, 5'h00, 0, 13'((k + 1) * 64), 0, 13'(k * 64 + 1), (k == 8), 0);
        end
        site = 13'h0240;
        for (int j = 0; j < 9; j++) begin
            add(0, 0, 8'h00, 5'h00, 0, 13'(site + 13'd1), 1, site, 1, 0);
            add(0, 0, 8'h00, 5'h00, 0, ret_tgt[j], 0, 13'(site + 13'd1), 1, (j == 8));
            site = ret_tgt[j];
        end
        run_table();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
